// File: rtl/ring_fifo_pkg.sv
// Shared types and sizing helpers for the ring_fifo block.
package ring_fifo_pkg;

    function automatic int count_width(input int lengthBits);
        return lengthBits + 1;
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic almostEmpty;
        logic almostFull;
        logic overflow;
        logic underflow;
    } status_t;

endpackage

// File: rtl/ring_fifo_mem.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
module ring_fifo_mem
    import ring_fifo_pkg::*;
#(
    parameter int WordSize   = 8,
    parameter int LengthBits = 3
) (
    input  logic                  clk,
    input  logic                  writeEnable,
    input  logic [LengthBits-1:0] writeAddr,
    input  logic [WordSize-1:0]   writeData,
    input  logic                  readEnable,
    input  logic [LengthBits-1:0] readAddr,
    output logic [WordSize-1:0]   readData
);

    logic [WordSize-1:0] mem [1 << LengthBits];

    // Read returns the pre-write word when both ports hit the same address.
    always_ff @(posedge clk) begin
        if (writeEnable) begin
            mem[writeAddr] <= writeData;
        end
        if (readEnable) begin
            readData <= mem[readAddr];
        end
    end

endmodule

// File: rtl/ring_fifo.sv
// Circular FIFO with occupancy count, thresholds and sticky overflow/underflow flags.
module ring_fifo
    import ring_fifo_pkg::*;
#(
    parameter int WordSize         = 8,
    parameter int LengthBits       = 3,
    parameter int AlmostFullLevel  = (1 << LengthBits) - 2,
    parameter int AlmostEmptyLevel = 1,
    parameter int OverwriteOnFull  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  dataWriteEnable,
    input  logic [WordSize-1:0]   dataWrite,
    input  logic                  dataReadEnable,
    output logic                  dataReadAck,
    output logic [WordSize-1:0]   dataRead,
    output logic [LengthBits:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  almostEmpty,
    output logic                  almostFull,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CountWidth = count_width(LengthBits);
    localparam logic [CountWidth-1:0] DepthC = CountWidth'(1 << LengthBits);
    localparam logic [CountWidth-1:0] AfC    = CountWidth'(AlmostFullLevel);
    localparam logic [CountWidth-1:0] AeC    = CountWidth'(AlmostEmptyLevel);
    localparam logic Overwrite = (OverwriteOnFull != 0);

    logic [LengthBits-1:0] rdPtr, wrPtr;
    logic [CountWidth-1:0] countQ;
    logic                  overflowQ, underflowQ, ackQ, haveData;
    logic [WordSize-1:0]   memData;
    status_t               status;
    logic                  doRead, doWrite, wrFull, dropOldest, active;

    always_comb begin
        status             = '0;
        status.empty       = (countQ == '0);
        status.full        = (countQ == DepthC);
        status.almostEmpty = (countQ <= AeC);
        status.almostFull  = (countQ >= AfC);
        status.overflow    = overflowQ;
        status.underflow   = underflowQ;
    end

    always_comb begin
        active     = reset && !flush;
        doRead     = dataReadEnable && !status.empty;
        wrFull     = dataWriteEnable && status.full && !doRead;
        doWrite    = dataWriteEnable && (!wrFull || Overwrite);
        dropOldest = wrFull && Overwrite;
    end

    ring_fifo_mem #(
        .WordSize   (WordSize),
        .LengthBits (LengthBits)
    ) u_mem (
        .clk         (clk),
        .writeEnable (active && doWrite),
        .writeAddr   (wrPtr),
        .writeData   (dataWrite),
        .readEnable  (active && doRead),
        .readAddr    (rdPtr),
        .readData    (memData)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdPtr      <= '0;
            wrPtr      <= '0;
            countQ     <= '0;
            overflowQ  <= 1'b0;
            underflowQ <= 1'b0;
            ackQ       <= 1'b0;
            haveData   <= 1'b0;
        end else if (flush) begin
            rdPtr      <= '0;
            wrPtr      <= '0;
            countQ     <= '0;
            overflowQ  <= 1'b0;
            underflowQ <= 1'b0;
            ackQ       <= 1'b0;
        end else begin
            ackQ <= doRead;
            if (doRead || dropOldest) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (doWrite) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doWrite && !doRead && !status.full) begin
                countQ <= countQ + 1'b1;
            end else if (doRead && !doWrite) begin
                countQ <= countQ - 1'b1;
            end
            if (wrFull) begin
                overflowQ <= 1'b1;
            end
            if (dataReadEnable && status.empty) begin
                underflowQ <= 1'b1;
            end
            if (doRead) begin
                haveData <= 1'b1;
            end
        end
    end

    // The unreset memory port is masked so dataRead reads zero until the first accepted read.
    assign dataRead    = haveData ? memData : '0;
    assign dataReadAck = ackQ;
    assign count       = countQ;
    assign empty       = status.empty;
    assign full        = status.full;
    assign almostEmpty = status.almostEmpty;
    assign almostFull  = status.almostFull;
    assign overflow    = status.overflow;
    assign underflow   = status.underflow;

endmodule

// File: tb/tb_ring_fifo.sv
// Self-checking bench for ring_fifo: drop-mode instance with a queue model, overwrite-mode instance for the overflow case.
module tb_ring_fifo;

    logic       clk = 1'b0;
    logic       reset, flush, dataWriteEnable, dataReadEnable;
    logic [7:0] dataWrite;

    logic       ack0, empty0, full0, ae0, af0, ov0, un0;
    logic [7:0] data0;
    logic [3:0] count0;
    logic       ack1, empty1, full1, ae1, af1, ov1, un1;
    logic [7:0] data1;
    logic [3:0] count1;

    int tests = 0;
    int fails = 0;

    logic [7:0] mq[$];
    logic [7:0] expq[$];
    bit         mov, mun;
    logic [7:0] lastData;

    always #5 clk = ~clk;

    ring_fifo #(.WordSize(8), .LengthBits(3), .OverwriteOnFull(0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .dataWriteEnable(dataWriteEnable), .dataWrite(dataWrite),
        .dataReadEnable(dataReadEnable), .dataReadAck(ack0), .dataRead(data0),
        .count(count0), .empty(empty0), .full(full0),
        .almostEmpty(ae0), .almostFull(af0), .overflow(ov0), .underflow(un0)
    );

    ring_fifo #(.WordSize(8), .LengthBits(3), .OverwriteOnFull(1)) dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .dataWriteEnable(dataWriteEnable), .dataWrite(dataWrite),
        .dataReadEnable(dataReadEnable), .dataReadAck(ack1), .dataRead(data1),
        .count(count1), .empty(empty1), .full(full1),
        .almostEmpty(ae1), .almostFull(af1), .overflow(ov1), .underflow(un1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; the model predicts, the DUT is sampled 1ns after the edge.
    task automatic step(input bit we, input logic [7:0] wd, input bit re, input bit fl);
        bit expAck;
        int sz;
        dataWriteEnable = we;
        dataWrite       = wd;
        dataReadEnable  = re;
        flush           = fl;
        expAck = 1'b0;
        if (fl) begin
            mq.delete();
            mov = 1'b0;
            mun = 1'b0;
        end else begin
            if (re && mq.size() > 0) begin
                expq.push_back(mq.pop_front());
                expAck = 1'b1;
            end
            if (we) begin
                if (mq.size() < 8) mq.push_back(wd);
                else mov = 1'b1;
            end
            if (re && !expAck) mun = 1'b1;
        end
        @(posedge clk);
        #1;
        dataWriteEnable = 1'b0;
        dataReadEnable  = 1'b0;
        flush           = 1'b0;
        chk("ack", ack0, expAck);
        if (ack0) begin
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_empty: got ack with data %0h, required no ack", data0);
            end else begin
                lastData = expq.pop_front();
                chk("data", data0, lastData);
            end
        end else begin
            if (expAck) void'(expq.pop_front());
            chk("hold", data0, lastData);
        end
        sz = mq.size();
        chk("count", count0, sz);
        chk("empty", empty0, sz == 0);
        chk("full", full0, sz == 8);
        chk("almostEmpty", ae0, sz <= 1);
        chk("almostFull", af0, sz >= 6);
        chk("overflow", ov0, mov);
        chk("underflow", un0, mun);
    endtask

    typedef struct {
        bit         we;
        logic [7:0] wd;
        bit         re;
        int         cnt;
        bit         ack;
    } vec_t;

    vec_t       tbl[16];
    logic [7:0] ow[8];

    initial begin
        for (int i = 0; i < 8; i++) begin
            tbl[i]     = '{1'b1, 8'(8'h10 + i), 1'b0, i + 1, 1'b0};
            tbl[8 + i] = '{1'b0, 8'h00, 1'b1, 7 - i, 1'b1};
            ow[i]      = (i < 7) ? 8'(i + 1) : 8'h99;
        end

        reset = 1'b0;
        flush = 1'b0;
        dataWriteEnable = 1'b0;
        dataReadEnable  = 1'b0;
        dataWrite = '0;
        mov = 1'b0;
        mun = 1'b0;
        lastData = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", count0, 0);
        chk("rst_empty", empty0, 1);
        chk("rst_full", full0, 0);
        chk("rst_ae", ae0, 1);
        chk("rst_af", af0, 0);
        chk("rst_ov", ov0, 0);
        chk("rst_un", un0, 0);
        chk("rst_ack", ack0, 0);
        chk("rst_data", data0, 0);
        chk("rst_count1", count1, 0);
        reset = 1'b1;

        // Fill and drain through the vector table.
        for (int k = 0; k < 16; k++) begin
            step(tbl[k].we, tbl[k].wd, tbl[k].re, 1'b0);
            chk("tbl_count", count0, tbl[k].cnt);
            chk("tbl_ack", ack0, tbl[k].ack);
            if (k == 7) chk("tbl_full", full0, 1);
        end
        chk("drain_last", data0, 8'h17);

        // Wrap-around past the top of the pointer range.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(i + 1), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk("wrap_data", data0, 8'(8'hA0 + i));
        end

        // Simultaneous read and write on a full FIFO.
        for (int i = 0; i < 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        chk("rw_full_data", data0, 8'h00);
        chk("rw_full_count", count0, 8);
        chk("rw_full_ov", ov0, 0);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("rw_full_last", data0, 8'h55);

        // Overflow in both modes.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b0);
        chk("ow_ov", ov1, 1);
        chk("ow_count", count1, 8);
        chk("ow_full", full1, 1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drop_data", data0, 8'(i));
            chk("ow_ack", ack1, 1);
            chk("ow_data", data1, ow[i]);
        end
        chk("ow_empty", empty1, 1);

        // Empty read with a simultaneous write: no fall-through.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        chk("er_ack", ack0, 0);
        chk("er_un", un0, 1);
        chk("er_count", count0, 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("er_data", data0, 8'h3C);

        // Flush with a concurrent write while underflow is still set.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        chk("fl_pre_af", af0, 0);
        chk("fl_pre_un", un0, 1);
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("fl_count", count0, 0);
        chk("fl_un", un0, 0);
        chk("fl_empty", empty0, 1);

        // Reset arriving during a read.
        step(1'b1, 8'h21, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        dataReadEnable = 1'b1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        dataReadEnable = 1'b0;
        reset = 1'b1;
        mq.delete();
        expq.delete();
        mov = 1'b0;
        mun = 1'b0;
        lastData = '0;
        chk("mr_ack", ack0, 0);
        chk("mr_data", data0, 0);
        chk("mr_empty", empty0, 1);
        chk("mr_count", count0, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
